// File: rtl/encode_42.sv
// encode_42: registered 4-to-2 binary encoder.
// Converts a one-hot request vector into its 2-bit index, with a valid flag
// for "any bit set" and an error flag for "more than one bit set".
// On multi-hot input the PRIO_HIGH parameter selects which set bit wins.
// All outputs come straight from flops; there is no combinational d -> output path.
module encode_42 #(
   parameter bit PRIO_HIGH = 1'b1   // 1: highest set bit wins, 0: lowest set bit wins
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d,
   output logic [1:0] a,
   output logic       valid,
   output logic       err
);

   logic [1:0] w_idx;
   logic       w_any;
   logic       w_multi;

   logic [1:0] r_a;
   logic       r_valid;
   logic       r_err;

   // Priority encode the request vector; direction fixed by PRIO_HIGH.
   always_comb begin
      w_idx = 2'b00;
      if (PRIO_HIGH) begin
         if (d[3])      w_idx = 2'd3;
         else if (d[2]) w_idx = 2'd2;
         else if (d[1]) w_idx = 2'd1;
         else           w_idx = 2'd0;
      end else begin
         if (d[0])      w_idx = 2'd0;
         else if (d[1]) w_idx = 2'd1;
         else if (d[2]) w_idx = 2'd2;
         else if (d[3]) w_idx = 2'd3;
         else           w_idx = 2'd0;
      end
   end

   // Flag generation: clearing the lowest set bit leaves something only when
   // two or more bits were set, which is the multi-hot condition.
   always_comb begin
      w_any   = |d;
      w_multi = |(d & (d - 4'd1));
   end

   // Output registers; a zero input yields index 0 rather than holding the old one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= 2'b00;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_a     <= w_idx;
         r_valid <= w_any;
         r_err   <= w_multi;
      end
   end

   assign a     = r_a;
   assign valid = r_valid;
   assign err   = r_err;

endmodule

// File: tb/tb_encode_42.sv
// tb_encode_42: directed bench for encode_42. Two instances share clock, reset
// and input: one built with highest-bit priority, one with lowest-bit priority.
// Outputs are compared as {a, valid, err} one time unit after the rising edge.
module tb_encode_42;

   logic       clk;
   logic       rst_n;
   logic [3:0] d;

   logic [1:0] a_hi, a_lo;
   logic       valid_hi, valid_lo;
   logic       err_hi, err_lo;

   int n_checks;
   int n_fail;

   logic [3:0] exp_hi_q[$];
   logic [3:0] exp_lo_q[$];

   encode_42 #(.PRIO_HIGH(1'b1)) u_dut_hi (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d),
      .a     (a_hi),
      .valid (valid_hi),
      .err   (err_hi)
   );

   encode_42 #(.PRIO_HIGH(1'b0)) u_dut_lo (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d),
      .a     (a_lo),
      .valid (valid_lo),
      .err   (err_lo)
   );

   // Clock: rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Change inputs just after the falling edge, away from the sampling edge.
   task automatic drive(input logic [3:0] val);
      @(negedge clk);
      #1;
      d = val;
   endtask

   task automatic test_reset();
      logic [3:0] obs;
      #3;
      obs = {a_hi, valid_hi, err_hi};
      if (obs !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_pre_edge_hi: got %b, want 0000", obs);
      end
      n_checks++;
      obs = {a_lo, valid_lo, err_lo};
      if (obs !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_pre_edge_lo: got %b, want 0000", obs);
      end
      n_checks++;
      // Edges while reset is held must not load d=1000.
      step();
      step();
      obs = {a_hi, valid_hi, err_hi};
      if (obs !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_held_hi: got %b, want 0000", obs);
      end
      n_checks++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_one_hot();
      logic [3:0] vec [4];
      logic [3:0] exp [4];
      logic [3:0] obs;
      vec = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      exp = '{4'b0010, 4'b0110, 4'b1010, 4'b1110};   // {a, valid, err}
      for (int i = 0; i < 4; i++) begin
         drive(vec[i]);
         for (int c = 0; c < 3; c++) begin
            step();
            obs = {a_hi, valid_hi, err_hi};
            if (obs !== exp[i]) begin
               n_fail++;
               $display("FAIL one_hot_hi d=%b cyc=%0d: got %b, want %b", vec[i], c, obs, exp[i]);
            end
            n_checks++;
            obs = {a_lo, valid_lo, err_lo};
            if (obs !== exp[i]) begin
               n_fail++;
               $display("FAIL one_hot_lo d=%b cyc=%0d: got %b, want %b", vec[i], c, obs, exp[i]);
            end
            n_checks++;
         end
      end
   endtask

   task automatic test_zero();
      logic [3:0] obs;
      drive(4'b1000);
      step();
      drive(4'b0000);
      step();
      obs = {a_hi, valid_hi, err_hi};
      if (obs !== 4'b0000) begin
         n_fail++;
         $display("FAIL zero_hi: got %b, want 0000", obs);
      end
      n_checks++;
      obs = {a_lo, valid_lo, err_lo};
      if (obs !== 4'b0000) begin
         n_fail++;
         $display("FAIL zero_lo: got %b, want 0000", obs);
      end
      n_checks++;
   endtask

   task automatic test_multi_hot();
      logic [3:0] vec    [5];
      logic [3:0] exp_hi [5];
      logic [3:0] exp_lo [5];
      logic [3:0] obs;
      vec    = '{4'b1010, 4'b0011, 4'b1100, 4'b0110, 4'b1111};
      exp_hi = '{4'b1111, 4'b0111, 4'b1111, 4'b1011, 4'b1111};
      exp_lo = '{4'b0111, 4'b0011, 4'b1011, 4'b0111, 4'b0011};
      for (int i = 0; i < 5; i++) begin
         drive(vec[i]);
         step();
         obs = {a_hi, valid_hi, err_hi};
         if (obs !== exp_hi[i]) begin
            n_fail++;
            $display("FAIL multi_hot_hi d=%b: got %b, want %b", vec[i], obs, exp_hi[i]);
         end
         n_checks++;
         obs = {a_lo, valid_lo, err_lo};
         if (obs !== exp_lo[i]) begin
            n_fail++;
            $display("FAIL multi_hot_lo d=%b: got %b, want %b", vec[i], obs, exp_lo[i]);
         end
         n_checks++;
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] vec [4];
      logic [3:0] exp [4];
      logic [3:0] prev_hi, prev_lo, want, obs;
      vec = '{4'b0001, 4'b1000, 4'b0100, 4'b0000};
      exp = '{4'b0010, 4'b1110, 4'b1010, 4'b0000};
      for (int i = 0; i < 4; i++) begin
         exp_hi_q.push_back(exp[i]);
         exp_lo_q.push_back(exp[i]);
      end
      // Previous state: the last multi-hot vector 1111.
      prev_hi = 4'b1111;
      prev_lo = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         drive(vec[i]);
         #1;
         // New d must not show before the edge.
         obs = {a_hi, valid_hi, err_hi};
         if (obs !== prev_hi) begin
            n_fail++;
            $display("FAIL b2b_pre_edge_hi i=%0d: got %b, want %b", i, obs, prev_hi);
         end
         n_checks++;
         obs = {a_lo, valid_lo, err_lo};
         if (obs !== prev_lo) begin
            n_fail++;
            $display("FAIL b2b_pre_edge_lo i=%0d: got %b, want %b", i, obs, prev_lo);
         end
         n_checks++;
         step();
         want = exp_hi_q.pop_front();
         obs = {a_hi, valid_hi, err_hi};
         if (obs !== want) begin
            n_fail++;
            $display("FAIL b2b_hi i=%0d: got %b, want %b", i, obs, want);
         end
         n_checks++;
         prev_hi = want;
         want = exp_lo_q.pop_front();
         obs = {a_lo, valid_lo, err_lo};
         if (obs !== want) begin
            n_fail++;
            $display("FAIL b2b_lo i=%0d: got %b, want %b", i, obs, want);
         end
         n_checks++;
         prev_lo = want;
      end
   endtask

   task automatic test_async_reset();
      logic [3:0] obs;
      drive(4'b0100);
      step();
      obs = {a_hi, valid_hi, err_hi};
      if (obs !== 4'b1010) begin
         n_fail++;
         $display("FAIL async_pre_hi: got %b, want 1010", obs);
      end
      n_checks++;
      // Pulse reset between edges (edge at +4 from here is avoided).
      #1;
      rst_n = 1'b0;
      #1;
      obs = {a_hi, valid_hi, err_hi};
      if (obs !== 4'b0000) begin
         n_fail++;
         $display("FAIL async_clear_hi: got %b, want 0000", obs);
      end
      n_checks++;
      obs = {a_lo, valid_lo, err_lo};
      if (obs !== 4'b0000) begin
         n_fail++;
         $display("FAIL async_clear_lo: got %b, want 0000", obs);
      end
      n_checks++;
      #1;
      rst_n = 1'b1;
      #1;
      obs = {a_hi, valid_hi, err_hi};
      if (obs !== 4'b0000) begin
         n_fail++;
         $display("FAIL async_released_no_edge_hi: got %b, want 0000", obs);
      end
      n_checks++;
      step();
      obs = {a_hi, valid_hi, err_hi};
      if (obs !== 4'b1010) begin
         n_fail++;
         $display("FAIL async_first_edge_hi: got %b, want 1010", obs);
      end
      n_checks++;
      obs = {a_lo, valid_lo, err_lo};
      if (obs !== 4'b1010) begin
         n_fail++;
         $display("FAIL async_first_edge_lo: got %b, want 1010", obs);
      end
      n_checks++;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      d        = 4'b1000;
      test_reset();
      test_one_hot();
      test_zero();
      test_multi_hot();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
